// File: rtl/writeback_arbiter_if.sv
// Handshake and status bundle between execute/LSU, the issue stage and the register file
// write port.
interface writeback_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_issue;
    logic [4:0]      ld_issue_rd;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            rf_wr_en;
    logic [4:0]      rf_wr_addr;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      query_addr0;
    logic [4:0]      query_addr1;
    logic            query_busy0;
    logic            query_busy1;
    logic            sb_err;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
        input  query_addr0, query_addr1,
        output alu_ready, rf_wr_en, rf_wr_addr, rf_wdata,
        output query_busy0, query_busy1, sb_err
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
        output query_addr0, query_addr1,
        input  alu_ready, rf_wr_en, rf_wr_addr, rf_wdata,
        input  query_busy0, query_busy1, sb_err
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU results (buffered in a small FIFO) and load responses onto the single RF
// write port, and tracks pending destinations for the issue-stage hazard check.
module writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               aresetn,
    writeback_arbiter_if.slave wb
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [4:0]            fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0]       fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    logic                  rf_wr_en;
    logic [4:0]            rf_wr_addr;
    logic [XLEN-1:0]       rf_wdata;

    logic [31:0]           pending;
    logic [31:0]           pending_nxt;
    logic [31:0]           fifo_mask;
    logic [31:0]           busy_mask;
    logic                  ld_err;
    logic                  sb_err;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = wb.alu_valid && !fifo_full;
    // Loads own the write port; the FIFO only drains on cycles without a load return.
    assign pop        = !wb.ld_valid && !fifo_empty;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_vld <= '0;
        end else begin
            if (push) begin
                wr_ptr           <= wr_ptr + 1'b1;
                fifo_vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr           <= rd_ptr + 1'b1;
                fifo_vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= wb.alu_rd;
            fifo_data[wr_ptr] <= wb.alu_data;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wdata   <= '0;
        end else if (wb.ld_valid) begin
            rf_wr_en   <= (wb.ld_rd != 5'd0);
            rf_wr_addr <= wb.ld_rd;
            rf_wdata   <= wb.ld_data;
        end else if (pop) begin
            rf_wr_en   <= (fifo_rd[rd_ptr] != 5'd0);
            rf_wr_addr <= fifo_rd[rd_ptr];
            rf_wdata   <= fifo_data[rd_ptr];
        end else begin
            rf_wr_en   <= 1'b0;
        end
    end

    // Clear before set so a same-cycle issue to a returning rd leaves it pending.
    always_comb begin
        pending_nxt = pending;
        if (wb.ld_valid) pending_nxt[wb.ld_rd] = 1'b0;
        if (wb.ld_issue) pending_nxt[wb.ld_issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
        ld_err = wb.ld_valid && (wb.ld_rd != 5'd0) && !pending[wb.ld_rd]
                 && !(wb.ld_issue && (wb.ld_issue_rd == wb.ld_rd));
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (ld_err) sb_err <= 1'b1;
        end
    end

    always_comb begin
        fifo_mask = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i]) fifo_mask[fifo_rd[i]] = 1'b1;
        end
        busy_mask = pending | fifo_mask;
        if (rf_wr_en) busy_mask[rf_wr_addr] = 1'b1;
        busy_mask[0] = 1'b0;
    end

    assign wb.alu_ready   = !fifo_full;
    assign wb.rf_wr_en    = rf_wr_en;
    assign wb.rf_wr_addr  = rf_wr_addr;
    assign wb.rf_wdata    = rf_wdata;
    assign wb.query_busy0 = busy_mask[wb.query_addr0];
    assign wb.query_busy1 = busy_mask[wb.query_addr1];
    assign wb.sb_err      = sb_err;
endmodule
